// File: rtl/alu_pkg.sv
// Shared constants for the nibble-serial ALU controller and its 4-bit datapath.
package alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Add and subtract propagate carry between nibbles; logic ops do not.
    function automatic logic is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU: add, subtract (a + ~b + cin), AND, OR.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic [1:0]          opcode,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] result,
    output logic                cout
);

    logic [NIBBLE_W:0] sum;

    always_comb begin
        sum = '0;
        unique case (opcode)
            OP_ADD:  sum = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
            OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, cin};
            OP_AND:  sum = {1'b0, a & b};
            default: sum = {1'b0, a | b};
        endcase
        result = sum[NIBBLE_W-1:0];
        cout   = sum[NIBBLE_W];
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Word-wide add/sub/AND/OR built by sequencing one 4-bit ALU over the operand
// nibbles, LSB first, with the carry chained through a register.
module alu_nibble_seq
    import alu_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NIBBLES*NIBBLE_W-1:0]   a,
    input  logic [NIBBLES*NIBBLE_W-1:0]   b,
    input  logic [1:0]                    opcode,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLES*NIBBLE_W-1:0]   result,
    output logic                          cout,
    output logic                          zero
);

    localparam int unsigned W  = NIBBLES * NIBBLE_W;
    localparam int unsigned KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [1:0]    op_q, op_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;

    logic [NIBBLE_W-1:0] a_nib, b_nib, alu_res;
    logic                alu_cout;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (k_q == KW'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    alu_4bit u_alu (
        .a      (a_nib),
        .b      (b_nib),
        .opcode (op_q),
        .cin    (carry_q),
        .result (alu_res),
        .cout   (alu_cout)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = opcode;
                    k_d     = '0;
                    carry_d = (opcode == OP_SUB);
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (k_q == KW'(i)) begin
                        acc_d[i*NIBBLE_W +: NIBBLE_W] = alu_res;
                    end
                end
                carry_d = is_arith(op_q) ? alu_cout : 1'b0;
                k_d     = k_q + KW'(1);
                // Outputs are loaded on the edge into DONE so they are visible alongside done.
                if (k_q == KW'(NIBBLES - 1)) begin
                    state_d  = S_DONE;
                    k_d      = '0;
                    result_d = acc_d;
                    cout_d   = carry_d;
                    zero_d   = (acc_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: transaction-level model checked every cycle plus directed literals.
module tb_alu_nibble_seq;

    localparam int NIB = 4;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   opcode = 2'b00;
    logic         ready, busy, done, cout, zero;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    alu_nibble_seq #(.NIBBLES(NIB)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level arithmetic: {carry_out, result}.
    function automatic logic [W:0] model_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [1:0] op);
        case (op)
            2'b00:   return {1'b0, x} + {1'b0, y};
            2'b01:   return {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
            2'b10:   return {1'b0, x & y};
            default: return {1'b0, x | y};
        endcase
    endfunction

    // m_left: 0 idle, NIB+1..2 running, 1 the done cycle.
    int           m_left = 0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_cout = 1'b0, m_zero = 1'b0, p_cout = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_zero <= 1'b0;
        end else if (m_left == 0) begin
            if (start) begin
                {p_cout, p_res} <= model_op(a, b, opcode);
                m_left          <= NIB + 1;
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_res  <= p_res;
                m_cout <= p_cout;
                m_zero <= (p_res == '0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready",  W'(ready),  W'(m_left == 0));
            check("busy",   W'(busy),   W'(m_left >= 2));
            check("done",   W'(done),   W'(m_left == 1));
            check("result", result,     m_res);
            check("cout",   W'(cout),   W'(m_cout));
            check("zero",   W'(zero),   W'(m_zero));
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [1:0] op,
                          input logic [W-1:0] er, input logic ec, input logic ez, input string nm);
        int n;
        bit got;
        @(posedge clk);
        #1;
        a = ta;
        b = tb_v;
        opcode = op;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        opcode = 2'($urandom);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        check({nm, "_latency"}, W'(n), W'(5));
        check({nm, "_result"}, result, er);
        check({nm, "_cout"}, W'(cout), W'(ec));
        check({nm, "_zero"}, W'(zero), W'(ez));
    endtask

    initial begin
        int ndone;
        logic [W-1:0] seen;

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_ready", W'(ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_result", result, W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(16'h1234, 16'h0FFF, 2'b00, 16'h2233, 1'b0, 1'b0, "add");
        run_op(16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b1, "add_wrap");
        run_op(16'h1000, 16'h0001, 2'b01, 16'h0FFF, 1'b1, 1'b0, "sub");
        run_op(16'h0001, 16'h0002, 2'b01, 16'hFFFF, 1'b0, 1'b0, "sub_borrow");
        run_op(16'hF0F0, 16'h3C3C, 2'b10, 16'h3030, 1'b0, 1'b0, "and");
        run_op(16'hF0F0, 16'h3C3C, 2'b11, 16'hFCFC, 1'b0, 1'b0, "or");

        // Second start during RUN must be ignored.
        @(posedge clk);
        #1;
        a = 16'h1234;
        b = 16'h0FFF;
        opcode = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h0001;
        b = 16'h0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        seen = '0;
        repeat (12) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                seen = result;
            end
        end
        check("busy_start_dones", W'(ndone), W'(1));
        check("busy_start_result", seen, 16'h2233);

        // Reset during RUN at k=2 aborts with no done.
        @(posedge clk);
        #1;
        a = 16'hAAAA;
        b = 16'h1111;
        opcode = 2'b00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", W'(ready), W'(1));
        check("abort_busy", W'(busy), W'(0));
        check("abort_result", result, W'(0));
        check("abort_cout", W'(cout), W'(0));
        check("abort_zero", W'(zero), W'(0));
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", W'(ndone), W'(0));
        run_op(16'h0003, 16'h0004, 2'b00, 16'h0007, 1'b0, 1'b0, "after_abort");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-cycle controller that performs 16-bit (parameterizable) add, subtract, AND and OR by sequencing a single `alu_4bit` datapath over successive nibbles, LSB first, chaining carry between passes. It sits between a requester issuing whole-word operations and the shared 4-bit ALU. It owns the operand/result registers, the nibble counter, the carry chain and the start/done handshake.

## Interface
- `NIBBLES`, default 4: number of 4-bit passes; word width W = 4*NIBBLES.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request; accepted only when `ready`=1.
- `a` in W: operand A, sampled on accept.
- `b` in W: operand B, sampled on accept.
- `opcode` in 2: 00 add, 01 sub, 10 AND, 11 OR; sampled on accept.
- `ready` out 1: controller idle, can accept `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle completion pulse.
- `result` out W: completed result, held until next completion.
- `cout` out 1: final carry; 1 = no borrow for sub; 0 for AND/OR.
- `zero` out 1: `result`==0, updated with `result`.

## Operation
- States:
  - IDLE: `ready`=1.
  - RUN: `busy`=1, nibble counter k = 0..NIBBLES-1.
  - DONE: `done`=1 for exactly one cycle.
- IDLE → RUN on `start`=1: latch `a`, `b`, `opcode`; k=0; carry register = 1 for sub, else 0.
- RUN, each cycle:
  - Drive `alu_4bit` with nibble k of latched A/B, latched opcode and the carry register.
  - Write the ALU result into nibble k of the accumulator.
  - Carry register ← ALU `cout` for add/sub; forced 0 for AND/OR.
  - k increments; at k=NIBBLES-1 go to DONE.
- DONE:
  - `result` ← accumulator, `cout` ← carry register, `zero` ← (accumulator==0).
  - `done`=1 for this cycle, then IDLE.
- ALU contract:
  - add: a+b+cin.
  - sub: a+~b+cin.
  - AND/OR: bitwise; ALU `cout` ignored.
- `start` while not in IDLE is ignored; no queuing. Input changes outside the accept cycle have no effect.
- Reset (any state, including mid-RUN): state=IDLE, k=0, carry=0, accumulator=0, `result`=0, `cout`=0, `zero`=0. The aborted operation produces no `done`.
- Output values after reset: `ready`=1, `busy`=0, `done`=0, `result`=0, `cout`=0, `zero`=0.

## Timing
- Accept at edge E0; RUN occupies cycles E0+1 .. E0+NIBBLES; DONE cycle is E0+NIBBLES+1, with `done`=1 and the new `result`/`cout`/`zero` visible in it.
- Latency start→done: NIBBLES+1 cycles (5 at default).
- Back-to-back throughput: one op per NIBBLES+2 cycles. `ready` returns the cycle after DONE.
- `ready` = (state==IDLE); `busy` = (state==RUN); both registered-state decodes, mutually exclusive, and both 0 during DONE.
- `result`/`cout`/`zero` change only on entry to DONE or on reset.

## Structure
- Shared package `alu_pkg`:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11;
  - state encoding S_IDLE, S_RUN, S_DONE;
  - NIBBLE_W=4.
- One sub-module: instance of the existing `alu_4bit` (a, b, opcode, cin, result, cout). Controller logic (FSM, counter, operand registers, nibble mux/demux, carry register) lives in `alu_nibble_seq`.

## Test plan
- Add no overflow: A=0x1234, B=0x0FFF, op=00 → `done` at start+5, result=0x2233, cout=0, zero=0.
- Add wrap: A=0xFFFF, B=0x0001, op=00 → result=0x0000, cout=1, zero=1; carry chains across all four nibbles.
- Subtract: A=0x1000, B=0x0001, op=01 → result=0x0FFF, cout=1. A=0x0001, B=0x0002 → result=0xFFFF, cout=0.
- Logic: A=0xF0F0, B=0x3C3C, op=10 → result=0x3030, cout=0. Same operands with op=11 → result=0xFCFC, cout=0.
- Start while busy: second `start` (A=0x0001, B=0x0001, op=00) pulsed during RUN → ignored. Single `done`, with the first op's result; `ready` low throughout RUN/DONE.
- Reset mid-op: assert `rst` at RUN cycle k=2 → next cycle ready=1, busy=0, result=0, cout=0, zero=0, no `done` pulse. A subsequent op 0x0003+0x0004 → 0x0007.
